// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM states and the NOP encoding.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h46C0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    // Instruction addresses are halfword aligned; bit 0 is always cleared.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return addr & ~{{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction buffer holding {pc, instr}; flush wins over push and pop.
module fetch_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        empty,
    output logic        full
);
    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign rdata   = mem[rd_ptr];

    // Storage is cleared on reset so decode sees zeros until the first fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding halfword request feeding a 2-entry buffer.
// Defining FETCH_PERF_CNT_EN adds the fetch_cnt/stall_cnt performance counters.
module fetch
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] data,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt
`endif
);
    fetch_state_t              state;
    fetch_state_t              next_state;
    logic [PC_W-1:0]           fetch_pc;
    logic [PC_W-1:0]           next_pc;
    logic                      push;
    logic                      pop;
    logic                      buf_empty;
    logic                      buf_full;
    logic [PC_W+INSTR_W-1:0]   buf_rdata;

    assign instr_valid = !buf_empty && !br_taken;
    assign pop         = instr_valid && instr_ready;
    assign imem_addr   = fetch_pc;
    assign data        = buf_rdata[INSTR_W-1:0];
    assign instr_pc    = buf_rdata[PC_W+INSTR_W-1:INSTR_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= next_state;
            fetch_pc <= next_pc;
        end
    end

    // A redirect overrides everything; a request already on the bus must still
    // have its response swallowed in DROP to keep a single outstanding request.
    always_comb begin
        next_state = state;
        next_pc    = fetch_pc;
        push       = 1'b0;
        imem_req   = 1'b0;

        case (state)
            IDLE:  next_state = ISSUE;
            ISSUE: begin
                imem_req   = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push       = 1'b1;
                    next_pc    = fetch_pc + 16'd2;
                    next_state = (buf_empty || pop) ? ISSUE : HOLD;
                end
            end
            HOLD: begin
                if (!buf_full || pop) next_state = ISSUE;
            end
            DROP: begin
                if (imem_rvalid) next_state = ISSUE;
            end
            default: next_state = IDLE;
        endcase

        if (br_taken) begin
            push    = 1'b0;
            next_pc = align_pc(br_target);
            case (state)
                ISSUE:   next_state = DROP;
                WAIT:    next_state = imem_rvalid ? ISSUE : DROP;
                DROP:    next_state = imem_rvalid ? ISSUE : DROP;
                default: next_state = ISSUE;
            endcase
        end
    end

    fetch_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (br_taken),
        .wdata ({fetch_pc, imem_rdata}),
        .rdata (buf_rdata),
        .empty (buf_empty),
        .full  (buf_full)
    );

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters: accepted instructions and back-pressure cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (pop && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
            if (instr_valid && !instr_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: instruction-stream model plus directed redirect/stall scenarios.
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [15:0] data;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [15:0] br_target;

    logic        req2;
    logic [15:0] addr2;
    logic        rv2;
    logic [15:0] rd2;
    logic [15:0] data2;
    logic [15:0] pc2;
    logic        valid2;
    logic        ready2;
    logic        br2;
    logic [15:0] target2;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
    logic [15:0] fetch_cnt2;
    logic [15:0] stall_cnt2;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .data        (data),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .br_target   (br_target)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    fetch #(.RESET_PC(16'hFFFC)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_rvalid (rv2),
        .imem_rdata  (rd2),
        .data        (data2),
        .instr_pc    (pc2),
        .instr_valid (valid2),
        .instr_ready (ready2),
        .br_taken    (br2),
        .br_target   (target2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt2),
        .stall_cnt   (stall_cnt2)
`endif
    );

    // Memory contents are a fixed function of address.
    function automatic logic [15:0] memword(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    // Memory responder for dut: programmable latency, one spurious pulse on demand.
    int          lat = 1;
    int          spur_req = 0;
    int          spur_done = 0;
    logic        pending = 1'b0;
    int          cnt = 0;
    logic [15:0] paddr = 16'h0;
    logic [15:0] req_log[$];

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0;
        forever begin
            logic busy;
            @(posedge clk);
            #1;
            busy        = pending;
            imem_rvalid = 1'b0;
            if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = memword(paddr);
                    pending     = 1'b0;
                end
            end else if (spur_req != spur_done) begin
                spur_done++;
                imem_rvalid = 1'b1;
                imem_rdata  = 16'hDEAD;
            end
            if (!reset && imem_req) begin
                checkOutput("single_outstanding", {31'b0, busy}, 32'd0);
                req_log.push_back(imem_addr);
                pending = 1'b1;
                paddr   = imem_addr;
                cnt     = lat;
            end
        end
    end

    // Fixed one-cycle memory for dut2.
    logic        p2 = 1'b0;
    logic [15:0] a2 = 16'h0;
    logic [15:0] log2[$];

    initial begin
        rv2     = 1'b0;
        rd2     = 16'h0;
        ready2  = 1'b1;
        br2     = 1'b0;
        target2 = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            rv2 = p2;
            rd2 = memword(a2);
            p2  = 1'b0;
            if (!reset && req2) begin
                p2 = 1'b1;
                a2 = addr2;
                log2.push_back(addr2);
            end
        end
    end

    // Stream model: decode must see consecutive halfwords from the last reset
    // or redirect target, nothing lost, duplicated or stale.
    logic [15:0] model_pc = 16'h0000;
    logic [15:0] model2_pc = 16'hFFFC;
    logic        prev_br = 1'b0;
    int          model_fetch = 0;
    int          model_stall = 0;
    int          model2_fetch = 0;

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("rst_req",   {31'b0, imem_req},    32'd0);
            checkOutput("rst_addr",  {16'b0, imem_addr},   32'h0000);
            checkOutput("rst_data",  {16'b0, data},        32'h0000);
            checkOutput("rst_pc",    {16'b0, instr_pc},    32'h0000);
            checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
            checkOutput("rst2_addr", {16'b0, addr2},       32'hFFFC);
`ifdef FETCH_PERF_CNT_EN
            checkOutput("rst_fetch_cnt", {16'b0, fetch_cnt}, 32'd0);
            checkOutput("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
`endif
            model_pc     = 16'h0000;
            model2_pc    = 16'hFFFC;
            prev_br      = 1'b0;
            model_fetch  = 0;
            model_stall  = 0;
            model2_fetch = 0;
        end else begin
`ifdef FETCH_PERF_CNT_EN
            checkOutput("fetch_cnt",  {16'b0, fetch_cnt},  model_fetch);
            checkOutput("stall_cnt",  {16'b0, stall_cnt},  model_stall);
            checkOutput("fetch_cnt2", {16'b0, fetch_cnt2}, model2_fetch);
`endif
            if (imem_req) checkOutput("addr_aligned", {31'b0, imem_addr[0]}, 32'd0);
            if (br_taken || prev_br) begin
                checkOutput("valid_after_branch", {31'b0, instr_valid}, 32'd0);
            end else if (instr_valid && instr_ready) begin
                checkOutput("stream_pc",   {16'b0, instr_pc}, {16'b0, model_pc});
                checkOutput("stream_data", {16'b0, data},     {16'b0, memword(model_pc)});
                model_pc = model_pc + 16'd2;
                if (model_fetch < 65535) model_fetch++;
            end
            if (instr_valid && !instr_ready && model_stall < 65535) model_stall++;
            if (br_taken) model_pc = br_target & 16'hFFFE;
            prev_br = br_taken;

            if (valid2) begin
                checkOutput("wrap_pc",   {16'b0, pc2},   {16'b0, model2_pc});
                checkOutput("wrap_data", {16'b0, data2}, {16'b0, memword(model2_pc)});
                model2_pc = model2_pc + 16'd2;
                if (model2_fetch < 65535) model2_fetch++;
            end
        end
    end

    // Advance to the next negedge at which dut issues a request.
    task automatic waitReq(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!imem_req && waited < 50);
        if (!imem_req) timeoutFail("req_timeout");
    endtask

    task automatic applyStimulus();
        int cyc;
        int acc;
        int reqs;
        int waited;
        int n;

        reset       = 1'b1;
        instr_ready = 1'b1;
        br_taken    = 1'b0;
        br_target   = 16'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // First instruction appears three edges after release.
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end while (!instr_valid && cyc < 20);
        checkOutput("first_valid_latency", cyc, 32'd3);
        checkOutput("first_pc",   {16'b0, instr_pc}, 32'h0000);
        checkOutput("first_data", {16'b0, data},     32'h5A5A);

        // Steady state delivers one instruction every two cycles.
        acc = (instr_valid && instr_ready) ? 1 : 0;
        repeat (19) begin
            @(negedge clk);
            if (instr_valid && instr_ready) acc++;
        end
        checkOutput("throughput", acc, 32'd10);
        checkOutput("addr0", {16'b0, req_log[0]}, 32'h0000);
        checkOutput("addr1", {16'b0, req_log[1]}, 32'h0002);
        checkOutput("addr2", {16'b0, req_log[2]}, 32'h0004);

        // Back-pressure: buffer fills, requests stop, stray rvalid ignored.
        @(posedge clk);
        #1 instr_ready = 1'b0;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 5 && imem_req) reqs++;
            if (i == 6) spur_req++;
        end
        checkOutput("hold_no_req",   reqs, 32'd0);
        checkOutput("hold_valid",    {31'b0, instr_valid}, 32'd1);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        repeat (8) @(posedge clk);

        // Redirect in WAIT with a slow response: response dropped, refetch at 0x0040.
        @(negedge clk);
        lat = 3;
        waitReq(waited);
        n = req_log.size();
        @(posedge clk);
        #1 br_taken = 1'b1;
        br_target = 16'h0041;
        @(posedge clk);
        #1 br_taken = 1'b0;
        waitReq(waited);
        checkOutput("late_drop_addr", {16'b0, imem_addr}, 32'h0040);
        checkOutput("late_drop_wait", waited, 32'd3);
        repeat (6) @(posedge clk);

        // Second redirect while already dropping retargets without a new request.
        @(negedge clk);
        waitReq(waited);
        n = req_log.size();
        @(posedge clk);
        #1 br_taken = 1'b1;
        br_target = 16'h0100;
        @(posedge clk);
        #1 br_target = 16'h0201;
        @(posedge clk);
        #1 br_taken = 1'b0;
        waitReq(waited);
        checkOutput("drop_retarget_addr", {16'b0, imem_addr}, 32'h0200);
        checkOutput("drop_retarget_count", req_log.size(), n + 1);
        repeat (6) @(posedge clk);

        // Redirect coincident with rvalid: discard response, issue target next cycle.
        @(negedge clk);
        lat = 1;
        waitReq(waited);
        waitReq(waited);
        @(posedge clk);
        #1 br_taken = 1'b1;
        br_target = 16'h1235;
        @(negedge clk);
        checkOutput("coincident_valid0", {31'b0, instr_valid}, 32'd0);
        @(posedge clk);
        #1 br_taken = 1'b0;
        @(negedge clk);
        checkOutput("coincident_valid1", {31'b0, instr_valid}, 32'd0);
        checkOutput("coincident_req",    {31'b0, imem_req},    32'd1);
        checkOutput("coincident_addr",   {16'b0, imem_addr},   32'h1234);

        // Mixed ready pattern exercising push/pop overlap and stall counting.
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1 instr_ready = (i % 3) != 1;
        end

        // Reset while holding a full buffer clears everything.
        @(posedge clk);
        #1 instr_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("midrun_rst_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("midrun_rst_addr",  {16'b0, imem_addr},   32'h0000);
        repeat (2) @(posedge clk);

        // RESET_PC near the top of memory wraps through zero.
        checkOutput("wrap_log_size", {31'b0, log2.size() >= 3}, 32'd1);
        if (log2.size() >= 3) begin
            checkOutput("wrap_addr0", {16'b0, log2[0]}, 32'hFFFC);
            checkOutput("wrap_addr1", {16'b0, log2[1]}, 32'hFFFE);
            checkOutput("wrap_addr2", {16'b0, log2[2]}, 32'h0000);
        end
    endtask

    initial begin
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
